// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO controller and its storage.
package fifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 3;
  localparam int DEPTH     = 1 << ASIZE_DEF;

  // Binary pointer: the low ASIZE bits address storage, and the MSB is the wrap bit.
  typedef logic [ASIZE_DEF:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write and asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             w_en,
  input  logic [ASIZE-1:0] w_addr,
  input  logic [DSIZE-1:0] data,
  input  logic [ASIZE-1:0] r_addr,
  output logic [DSIZE-1:0] out
);

  logic [DSIZE-1:0] mem [1 << ASIZE];

  // Capture write data on the rising edge whenever the controller enables a write.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= data;
  end

  // The read is combinational, so the head entry falls through without a read cycle.
  always_comb begin
    out = mem[r_addr];
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy flags and valid/ready
// handshakes around fifo_mem. Every flag is decoded from the registered pointers.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int ASIZE     = ASIZE_DEF,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DSIZE-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [DSIZE-1:0] rd_data,
  output logic [ASIZE:0]   count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam logic [ASIZE:0] AFULL_LIM  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_LIM = (ASIZE+1)'(AEMPTY_TH);
  localparam logic [ASIZE:0] PTR_ONE    = (ASIZE+1)'(1);

  logic [ASIZE:0]   wptr, rptr;
  logic             empty, full;
  logic             push, pop;
  logic [ASIZE-1:0] w_addr, r_addr;

  // Decode status, handshakes and memory addresses from the registered pointers.
  always_comb begin
    empty        = (wptr == rptr);
    full         = (wptr[ASIZE] != rptr[ASIZE]) &&
                   (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    count        = wptr - rptr;
    wr_ready     = !full;
    rd_valid     = !empty;
    almost_full  = (count >= AFULL_LIM);
    almost_empty = (count <= AEMPTY_LIM);
    push         = wr_valid && wr_ready && !flush;
    pop          = rd_valid && rd_ready && !flush;
    w_addr       = wptr[ASIZE-1:0];
    r_addr       = rptr[ASIZE-1:0];
  end

  // Advance the pointers on push and pop. Flush takes priority and returns both pointers to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk    (clk),
    .w_en   (push),
    .w_addr (w_addr),
    .data   (wr_data),
    .r_addr (r_addr),
    .out    (rd_data)
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl, with hand-computed expectations.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       almost_full;
  logic       almost_empty;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_ctrl #(
    .DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    int         ops;

    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    #12;
    chk("rst_count",  32'(count), 32'd0);
    chk("rst_rvalid", 32'(rd_valid), 32'd0);
    chk("rst_wready", 32'(wr_ready), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull",  32'(almost_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Fill phase
    wr_valid = 1'b1; wr_data = 8'h55;
    tick();
    chk("fill1_count", 32'(count), 32'd1);
    chk("fill1_rvalid", 32'(rd_valid), 32'd1);
    chk("fill1_head", 32'(rd_data), 32'h55);
    wr_data = 8'hF0;
    tick();
    chk("fill2_count", 32'(count), 32'd2);
    wr_data = 8'hE8;
    tick();
    chk("fill3_count", 32'(count), 32'd3);
    chk("fill3_head", 32'(rd_data), 32'h55);
    wr_valid = 1'b0;

    // Full phase: start from an empty FIFO
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush0_count", 32'(count), 32'd0);
    wr_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_data = 8'(i);
      tick();
    end
    chk("full_wready", 32'(wr_ready), 32'd0);
    chk("full_count",  32'(count), 32'd8);
    chk("full_afull",  32'(almost_full), 32'd1);
    wr_data = 8'h09;
    tick();
    chk("full9_count", 32'(count), 32'd8);
    chk("full9_head",  32'(rd_data), 32'h01);
    wr_valid = 1'b0;

    // Drain phase: entries must come out in order
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", 32'(rd_data), 32'(i));
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_rvalid", 32'(rd_valid), 32'd0);
    chk("drain_aempty", 32'(almost_empty), 32'd1);
    chk("drain_count",  32'(count), 32'd0);

    // Simultaneous push and pop at count = 4
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick();
    end
    chk("sim_pre_count", 32'(count), 32'd4);
    wr_data = 8'hAA; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("sim_count", 32'(count), 32'd4);
    chk("sim_pop_seq", 32'(rd_data), 32'h11);
    tick();
    chk("sim_pop_seq", 32'(rd_data), 32'h12);
    tick();
    chk("sim_pop_seq", 32'(rd_data), 32'h13);
    tick();
    chk("sim_last", 32'(rd_data), 32'hAA);
    tick();
    rd_ready = 1'b0;
    chk("sim_empty", 32'(rd_valid), 32'd0);

    // Wrap-around phase: start from zero pointers and interleave one push with one pop
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ops = 0;
    for (int i = 0; i < 20; i++) begin
      v = 8'h40 + 8'(i * 3);
      wr_valid = 1'b1; wr_data = v;
      tick();
      wr_valid = 1'b0;
      ops++;
      chk("wrap_rvalid", 32'(rd_valid), 32'd1);
      chk("wrap_data", 32'(rd_data), 32'(v));
      chk("wrap_wmsb", 32'(dut.wptr[3]), 32'((ops % 16) >= 8));
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      chk("wrap_popped", 32'(rd_valid), 32'd0);
    end

    // Flush with a concurrent write drops the write
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h20 + 8'(i);
      tick();
    end
    chk("fl_pre_count", 32'(count), 32'd5);
    flush = 1'b1; wr_data = 8'h77;
    tick();
    flush = 1'b0; wr_valid = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_rvalid", 32'(rd_valid), 32'd0);

    // Refill to 3 entries, then apply async reset between edges
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h30 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("ar_pre_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count",  32'(count), 32'd0);
    chk("ar_rvalid", 32'(rd_valid), 32'd0);
    chk("ar_wready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
